// File: rtl/line_scanout.sv
// Ring buffer of the most recent terrain lines, refreshed only during vertical
// blanking, serialised to a 1-bit pixel stream from the VGA timing counters.
module line_scanout #(
  parameter int WIDTH     = 640,
  parameter int ROWS      = 8,
  parameter int ROW_SHIFT = 4,
  parameter int Y_TOP     = 352
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] line_i,
  input  logic             line_stb_i,
  input  logic [9:0]       hcount_i,
  input  logic [9:0]       vcount_i,
  input  logic             video_on_i,
  input  logic             vblank_i,
  output logic             pixel_o,
  output logic             in_band_o,
  output logic             commit_o,
  output logic             drop_o,
  output logic [7:0]       drop_cnt_o
);

  localparam int          PTR_W  = $clog2(ROWS);
  localparam logic [9:0]  YTOP_V = 10'(Y_TOP);
  localparam logic [10:0] YTOP_L = 11'(Y_TOP);
  localparam logic [10:0] YEND_L = 11'(Y_TOP + (ROWS << ROW_SHIFT));
  localparam logic [10:0] XEND_L = 11'(WIDTH);

  typedef enum logic [1:0] {IDLE, PEND, WRITE} StateT;

  StateT             state_q, state_d;
  logic              stbMeta_q, stbSync_q, stbPrev_q;
  logic              stbEdge;
  logic [WIDTH-1:0]  hold_q;
  logic [WIDTH-1:0]  ring_q [ROWS];
  logic [PTR_W-1:0]  wrPtr_q;
  logic [7:0]        dropCnt_q;
  logic              pixel_q, inBand_q;
  logic              band;
  logic [PTR_W-1:0]  rowIdx, slot;

  // The generator's line clock is foreign to clk_i, so it is synchronised
  // before its rising edge is detected.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stbMeta_q <= 1'b0;
      stbSync_q <= 1'b0;
      stbPrev_q <= 1'b0;
    end else begin
      stbMeta_q <= line_stb_i;
      stbSync_q <= stbMeta_q;
      stbPrev_q <= stbSync_q;
    end
  end

  assign stbEdge = stbSync_q & ~stbPrev_q;

  always_comb begin
    state_d  = state_q;
    commit_o = 1'b0;
    drop_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stbEdge) state_d = vblank_i ? WRITE : PEND;
      end
      PEND: begin
        drop_o = stbEdge;
        if (vblank_i) state_d = WRITE;
      end
      WRITE: begin
        commit_o = 1'b1;
        state_d  = stbEdge ? PEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every state captures a fresh line on the edge; a WRITE still stores the
  // previous hold value because the capture lands on the same clock edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      hold_q    <= '1;
      wrPtr_q   <= '0;
      dropCnt_q <= 8'd0;
      for (int i = 0; i < ROWS; i++) ring_q[i] <= '1;
    end else begin
      state_q <= state_d;
      if (stbEdge) hold_q <= line_i;
      if (state_q == WRITE) begin
        ring_q[wrPtr_q] <= hold_q;
        wrPtr_q         <= wrPtr_q + PTR_W'(1);
      end
      if (drop_o && dropCnt_q != 8'hFF) dropCnt_q <= dropCnt_q + 8'd1;
    end
  end

  always_comb begin
    band = video_on_i
        && ({1'b0, vcount_i} >= YTOP_L)
        && ({1'b0, vcount_i} <  YEND_L)
        && ({1'b0, hcount_i} <  XEND_L);
    rowIdx = PTR_W'((vcount_i - YTOP_V) >> ROW_SHIFT);
    slot   = wrPtr_q + rowIdx;
  end

  // The band gate short-circuits the column read, so hcount beyond WIDTH
  // never selects a real bit.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pixel_q  <= 1'b0;
      inBand_q <= 1'b0;
    end else begin
      pixel_q  <= band && ring_q[slot][hcount_i];
      inBand_q <= band;
    end
  end

  assign pixel_o    = pixel_q;
  assign in_band_o  = inBand_q;
  assign drop_cnt_o = dropCnt_q;

endmodule
